neuron_layer_seq: RTL and testbench

//  Time-multiplexed controller/datapath for one fully-connected layer of M ReLU neurons of N inputs each.

---
 rtl/neuron_layer_seq.sv | 141 ++++++++++++++
 tb/tb_neuron_layer_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: one fully-connected layer of M neurons x N inputs sharing a single MAC.
// Define RELU_EN for ReLU outputs; otherwise outputs are the linear sum.
module neuron_layer_seq #(
  parameter int unsigned N      = 4,
  parameter int unsigned M      = 3,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N + 1),
  localparam int unsigned AW    = $clog2(M * (N + 1)),
  localparam int unsigned IW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*WIDTH-1:0]      in_x,
  output logic                    w_rd_en,
  output logic [AW-1:0]           w_addr,
  input  logic signed [WIDTH-1:0] w_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_y,
  output logic [IW-1:0]           out_idx,
  output logic                    out_last
);

  localparam int unsigned CW = $clog2(N + 2);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                    state_q, state_d;
  logic [N*WIDTH-1:0]        x_q, x_d;
  logic [CW-1:0]             c_q, c_d;
  logic [IW-1:0]             j_q, j_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      last_q, last_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   y_q, y_d;
  logic signed [ACC_W-1:0]   sum, f_sum;
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [2*WIDTH-1:0] prod;

  // Read data in cycle c belongs to the address issued in cycle c-1, so pair it with x[c-1].
  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (c_q == CW'(k + 1)) x_sel = x_q[k*WIDTH +: WIDTH];
    end
  end

  assign prod = x_sel * w_rdata;
  assign sum  = acc_q + ACC_W'(w_rdata);

`ifdef RELU_EN
  assign f_sum = sum[ACC_W-1] ? '0 : sum;
`else
  assign f_sum = sum;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    c_d       = c_q;
    j_d       = j_q;
    acc_d     = acc_q;
    y_d       = y_q;
    idx_d     = idx_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_rd_en   = 1'b0;
    w_addr    = '0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_x;
          j_d     = '0;
          c_d     = '0;
          acc_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (c_q <= CW'(N)) begin
          w_rd_en = 1'b1;
          w_addr  = AW'(32'(j_q) * (N + 1) + 32'(c_q));
        end
        if (c_q != '0 && c_q <= CW'(N)) acc_d = acc_q + ACC_W'(prod);
        if (c_q == CW'(N + 1)) begin
          y_d     = f_sum;
          idx_d   = j_q;
          last_d  = (j_q == IW'(M - 1));
          state_d = StOut;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (j_q != IW'(M - 1)) begin
            j_d     = j_q + 1'b1;
            c_d     = '0;
            acc_d   = '0;
            state_d = StAcc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      c_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      c_q     <= c_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_y    = y_q;
  assign out_idx  = idx_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Self-checking bench for neuron_layer_seq: directed steps plus random vectors against a
// plain-arithmetic dot-product model; an external synchronous weight memory lives here.
module tb_neuron_layer_seq;

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 3;
  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 2 * W + $clog2(N + 1);
  localparam int unsigned AW    = $clog2(M * (N + 1));
  localparam int unsigned IW    = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NW    = M * (N + 1);
  localparam logic [31:0] YMASK = (32'd1 << ACC_W) - 32'd1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic [N*W-1:0]      in_x = '0;
  logic signed [W-1:0] w_rdata = '0;
  logic                in_ready, w_rd_en, out_valid, out_last;
  logic [AW-1:0]       w_addr;
  logic [ACC_W-1:0]    out_y;
  logic [IW-1:0]       out_idx;

  logic signed [W-1:0] wmem [NW];
  int                  cyc = 0;
  int                  passed = 0;
  int                  total = 0;
  int                  hs_cyc = 0;
  int                  out_hs_cyc = 0;
  int                  exp_y [M];
  int                  spec_y [M];
  bit                  spec_v [M];
  bit                  hold_valid = 1'b0;
  int unsigned         addr_log [$];

  neuron_layer_seq #(.N(N), .M(M), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (w_rd_en) w_rdata <= wmem[w_addr];
  always @(posedge clk) if (rst_n && w_rd_en) addr_log.push_back(32'(w_addr));

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference: bias + sum of x[k]*w[j][k], then the activation.
  function automatic int model(input int j, input logic [N*W-1:0] x);
    int s;
    s = int'(wmem[j*(N+1)+N]);
    for (int k = 0; k < N; k++) s += int'($signed(x[k*W +: W])) * int'(wmem[j*(N+1)+k]);
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_w();
    for (int i = 0; i < NW; i++) wmem[i] = W'($urandom);
  endtask

  function automatic logic [N*W-1:0] rand_x();
    logic [N*W-1:0] x;
    for (int k = 0; k < N; k++) x[k*W +: W] = W'($urandom);
    return x;
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_y"},     32'(out_y), 0);
    chk({tag, "_out_idx"},   32'(out_idx), 0);
    chk({tag, "_out_last"},  32'(out_last), 0);
    chk({tag, "_w_rd_en"},   32'(w_rd_en), 0);
    chk({tag, "_w_addr"},    32'(w_addr), 0);
  endtask

  task automatic send(input logic [N*W-1:0] x);
    int n;
    n = 0;
    in_x = x;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
    for (int j = 0; j < M; j++) exp_y[j] = model(j, x);
    step();
    hs_cyc = cyc;
    if (!hold_valid) in_valid = 1'b0;
    in_x = rand_x();  // must be ignored while the vector is processed
  endtask

  task automatic collect(input int j, input int stall);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("out_valid_wait", 32'(out_valid), 1);
    // Cycles counted from the handshake cycle to the first cycle with out_valid.
    chk("latency", 32'(cyc - ((j == 0) ? hs_cyc : out_hs_cyc) + 1), N + 3);
    chk("y", 32'(out_y), 32'(exp_y[j]) & YMASK);
    if (spec_v[j]) chk("spec_y", 32'(out_y), 32'(spec_y[j]) & YMASK);
    chk("idx", 32'(out_idx), 32'(j));
    chk("last", 32'(out_last), 32'(j == M - 1));
    chk("in_ready_busy", 32'(in_ready), 0);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_y", 32'(out_y), 32'(exp_y[j]) & YMASK);
        chk("stall_idx", 32'(out_idx), 32'(j));
        chk("stall_last", 32'(out_last), 32'(j == M - 1));
        chk("stall_rd_en", 32'(w_rd_en), 0);
      end
      out_ready = 1'b1;
    end
    step();
    out_hs_cyc = cyc;
  endtask

  task automatic check_addrs();
    chk("rd_count", 32'(addr_log.size()), NW);
    for (int i = 0; i < addr_log.size() && i < NW; i++) chk("rd_addr", addr_log[i], 32'(i));
    addr_log.delete();
  endtask

  task automatic run_vector(input logic [N*W-1:0] x, input int stall_j, input int stall_n);
    send(x);
    for (int j = 0; j < M; j++) collect(j, (j == stall_j) ? stall_n : 0);
    check_addrs();
  endtask

  initial begin
    logic [N*W-1:0] x1, x2;
    bit seen;
    for (int i = 0; i < NW; i++) wmem[i] = '0;
    for (int j = 0; j < M; j++) spec_v[j] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("reset_in_ready", 32'(in_ready), 1);

    // Latency, address sequence and activation on a negative sum
    rand_w();
    for (int k = 0; k < N; k++) begin
      wmem[k] = 8'sd1;
      wmem[(N+1)+k] = -8'sd1;
    end
    wmem[N] = 8'sd0;
    wmem[(N+1)+N] = 8'sd5;
    spec_y[0] = 10;
    spec_v[0] = 1'b1;
`ifdef RELU_EN
    spec_y[1] = 0;
`else
    spec_y[1] = -5;
`endif
    spec_v[1] = 1'b1;
    send({8'd4, 8'd3, 8'd2, 8'd1});
    for (int c = 0; c <= N + 1; c++) begin
      chk("acc_rd_en", 32'(w_rd_en), 32'(c <= N));
      if (c <= N) chk("acc_addr", 32'(w_addr), 32'(c));
      step();
    end
    for (int j = 0; j < M; j++) collect(j, 0);
    check_addrs();

    // Extremes, with backpressure on neuron 1
    for (int k = 0; k < N; k++) begin
      wmem[k] = -8'sd128;
      wmem[(N+1)+k] = 8'sd127;
    end
    wmem[N] = 8'sd127;
    wmem[(N+1)+N] = -8'sd128;
    spec_y[0] = 65663;
`ifdef RELU_EN
    spec_y[1] = 0;
`else
    spec_y[1] = -65152;
`endif
    run_vector({N{8'h80}}, 1, 5);
    spec_v[0] = 1'b0;
    spec_v[1] = 1'b0;

    // Reset during neuron 1 accumulation
    rand_w();
    send(rand_x());
    collect(0, 0);
    repeat (3) step();
    chk("midrst_busy_rd_en", 32'(w_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    addr_log.delete();
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("midrst_in_ready", 32'(in_ready), 1);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= out_valid;
    end
    chk("midrst_no_stale_out", 32'(seen), 0);
    run_vector(rand_x(), M, 0);

    // Back-to-back vectors with in_valid held high
    rand_w();
    x1 = rand_x();
    x2 = rand_x();
    hold_valid = 1'b1;
    send(x1);
    for (int j = 0; j < M; j++) collect(j, 0);
    check_addrs();
    chk("b2b_in_ready", 32'(in_ready), 1);
    hold_valid = 1'b0;
    send(x2);
    chk("b2b_accept_cycle", 32'(hs_cyc - out_hs_cyc), 1);
    for (int j = 0; j < M; j++) collect(j, 0);
    check_addrs();

    // Random vectors and weights with random stalls
    repeat (6) begin
      rand_w();
      run_vector(rand_x(), int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
